// File: rtl/dct_pkg.sv
// Shared types and constants for the 4x4 DCT row sequencer.
// Element layout {s, e[7:0], m[23:0]}; a row packs four elements, element 0 at the MSB.
package dct_pkg;

    localparam int FP_W  = 33;
    localparam int ROW_W = 132;
    localparam int N     = 4;

    localparam int SGN_B  = 32;
    localparam int EXP_HI = 31;
    localparam int EXP_LO = 24;
    localparam int MAN_HI = 23;
    localparam int MAN_LO = 0;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
    } fp_t;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/dct_row_fifo.sv
// Show-ahead synchronous FIFO for result rows tagged with their index.
// Ports: clk, reset (async active-low), push/din, pop/dout, empty, full, count.
module dct_row_fifo
    import dct_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int W     = ROW_W + 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic          do_push;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // Head is forced to zero when empty so idle outputs stay clean.
    assign dout    = empty ? '0 : mem[rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= inc(wr);
            if (do_pop)  rd <= inc(rd);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end

endmodule

// File: rtl/dct4_2d_ctrl.sv
// Block sequencer for the 4x4 2D DCT datapath: gathers 4 rows, issues them back to back,
// tracks datapath latency and buffers results. Ports: in_* (rows in), dp_* (datapath), out_* (results), busy.
module dct4_2d_ctrl
    import dct_pkg::*;
#(
    parameter int LAT   = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_row,
    output logic             dp_valid,
    output logic             dp_first,
    output logic [ROW_W-1:0] dp_x,
    input  logic [ROW_W-1:0] dp_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t           state;
    logic [1:0]       cnt;
    logic [1:0]       iidx;
    logic [1:0]       nidx;
    logic [ROW_W-1:0] rbuf [N];
    logic [CW-1:0]    credits;
    logic [LAT-1:0]   tv;
    logic [1:0]       ti [LAT];

    logic             accept;
    logic             pop;
    logic             cred_ok;
    logic             res;
    logic             fempty;
    logic             ffull;
    logic [CW-1:0]    fcount;

    assign accept  = in_valid & in_ready;
    assign pop     = out_valid & out_ready;
    assign cred_ok = (credits >= CW'(4));
    assign nidx    = iidx + 2'd1;

    // res: ISSUE is entered at the coming edge; output space is reserved then.
    always_comb begin
        res = 1'b0;
        unique case (state)
            S_FILL:  res = accept && (cnt == 2'd3) && cred_ok;
            S_WAIT:  res = cred_ok;
            default: res = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) rbuf[cnt] <= in_row;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FILL;
            cnt      <= '0;
            iidx     <= '0;
            in_ready <= 1'b0;
            dp_valid <= 1'b0;
            dp_first <= 1'b0;
            dp_x     <= '0;
        end else begin
            dp_first <= 1'b0;
            unique case (state)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            in_ready <= 1'b0;
                            state    <= cred_ok ? S_ISSUE : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cred_ok) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (iidx == 2'd3) begin
                        state    <= S_FILL;
                        in_ready <= 1'b1;
                        dp_valid <= 1'b0;
                        dp_x     <= '0;
                    end else begin
                        iidx <= nidx;
                        dp_x <= rbuf[nidx];
                    end
                end
                default: state <= S_FILL;
            endcase
            if (res) begin
                dp_valid <= 1'b1;
                dp_first <= 1'b1;
                dp_x     <= rbuf[0];
                iidx     <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= CW'(DEPTH);
        end else begin
            credits <= credits
                     - (res ? CW'(4) : CW'(0))
                     + (pop ? CW'(1) : CW'(0));
        end
    end

    // Latency shadow of the datapath: tail valid means dp_y holds a result now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tv <= '0;
            for (int i = 0; i < LAT; i++) ti[i] <= '0;
        end else begin
            tv[0] <= dp_valid;
            ti[0] <= iidx;
            for (int i = 1; i < LAT; i++) begin
                tv[i] <= tv[i-1];
                ti[i] <= ti[i-1];
            end
        end
    end

    dct_row_fifo #(
        .DEPTH (DEPTH),
        .W     (ROW_W + 2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tv[LAT-1]),
        .din   ({dp_y, ti[LAT-1]}),
        .pop   (pop),
        .dout  ({out_row, out_idx}),
        .empty (fempty),
        .full  (ffull),
        .count (fcount)
    );

    // Credits reserve space before issue, so a push into a full FIFO is a bug.
    always_ff @(posedge clk) begin
        if (reset && tv[LAT-1]) assert (!ffull);
    end

    assign out_valid = ~fempty;
    assign out_last  = out_valid & (out_idx == 2'd3);
    assign busy      = (state != S_FILL) | (cnt != 2'd0)
                     | (|tv) | (fcount != '0);

endmodule

// File: tb/tb_dct4_2d_ctrl.sv
// Bench for dct4_2d_ctrl: directed blocks, cycle model of rows/credits, fake datapath (~x after LAT).
// Ports of the DUT are all driven/observed here.
module tb_dct4_2d_ctrl;
    import dct_pkg::*;

    localparam int LAT   = 6;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [131:0] in_row = '0;
    logic         dp_valid;
    logic         dp_first;
    logic [131:0] dp_x;
    logic [131:0] dp_y;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [131:0] out_row;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         busy;

    dct4_2d_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .dp_valid  (dp_valid),
        .dp_first  (dp_first),
        .dp_x      (dp_x),
        .dp_y      (dp_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [131:0] act,
                       input logic [131:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Fake datapath: result is ~x, appearing LAT cycles after issue.
    logic [131:0] pipe [LAT+1];
    initial for (int i = 0; i <= LAT; i++) pipe[i] = '0;
    always @(negedge clk) begin
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = ~dp_x;
    end
    assign dp_y = pipe[LAT];

    // Behavioural model: held rows, issue burst, free output slots, result queue.
    typedef struct {
        logic [131:0] d;
        logic [1:0]   idx;
        int           arr;
    } orow_t;

    logic [131:0] hold_q [$];
    logic [131:0] iss_q [$];
    orow_t        oq [$];
    int           cred = DEPTH;
    int           iss_left = 0;
    bit           rdy = 1'b0;

    always @(negedge clk) begin
        bit    exp_ov, exp_busy, acc, pop, start;
        int    nc;
        orow_t o;
        if (!reset) begin
            hold_q.delete();
            iss_q.delete();
            oq.delete();
            cred = DEPTH;
            iss_left = 0;
            rdy = 1'b0;
            chk("rst_in_ready", 132'(in_ready), 132'(0));
            chk("rst_dp_valid", 132'(dp_valid), 132'(0));
            chk("rst_dp_x", dp_x, 132'(0));
            chk("rst_out_valid", 132'(out_valid), 132'(0));
            chk("rst_busy", 132'(busy), 132'(0));
        end else begin
            exp_ov   = (oq.size() > 0) && (oq[0].arr <= cyc);
            exp_busy = (hold_q.size() > 0) || (iss_left > 0) || (oq.size() > 0);
            chk("in_ready", 132'(in_ready), 132'(rdy));
            chk("dp_valid", 132'(dp_valid), 132'(iss_left > 0));
            chk("dp_first", 132'(dp_first), 132'(iss_left == 4));
            chk("dp_x", dp_x, (iss_left > 0) ? iss_q[4-iss_left] : 132'(0));
            chk("out_valid", 132'(out_valid), 132'(exp_ov));
            if (exp_ov) begin
                chk("out_row", out_row, oq[0].d);
                chk("out_idx", 132'(out_idx), 132'(oq[0].idx));
                chk("out_last", 132'(out_last), 132'(oq[0].idx == 2'd3));
            end
            chk("busy", 132'(busy), 132'(exp_busy));

            acc = in_valid && rdy;
            pop = exp_ov && out_ready;
            if (pop) void'(oq.pop_front());
            if (iss_left > 0) begin
                o.d   = ~iss_q[4-iss_left];
                o.idx = 2'(4 - iss_left);
                o.arr = cyc + LAT + 1;
                oq.push_back(o);
                iss_left--;
            end
            if (acc) hold_q.push_back(in_row);
            start = (iss_left == 0) && (hold_q.size() == 4) && (cred >= 4);
            nc = cred + (pop ? 1 : 0);
            if (start) begin
                iss_q = hold_q;
                hold_q.delete();
                iss_left = 4;
                nc -= 4;
            end
            cred = nc;
            rdy = (iss_left == 0) && (hold_q.size() < 4);
        end
    end

    // Event log used by the directed timing checks.
    int           dpv_total = 0;
    int           pop_total = 0;
    int           last_total = 0;
    int           first_q [$];
    int           ovrise_q [$];
    logic [32:0]  e0_q [$];
    bit           ov_prev = 1'b0;

    always @(negedge clk) begin
        if (dp_valid) dpv_total++;
        if (dp_valid && dp_first) first_q.push_back(cyc);
        if (out_valid && !ov_prev) begin
            ovrise_q.push_back(cyc);
            e0_q.push_back(out_row[131:99]);
        end
        ov_prev = out_valid;
        if (out_valid && out_ready) begin
            pop_total++;
            if (out_last) last_total++;
        end
    end

    function automatic logic [131:0] mkrow(input int b, input int r);
        logic [131:0] row;
        fp_t          e;
        row = '0;
        for (int k = 0; k < 4; k++) begin
            e.s = 1'(k ^ r);
            e.e = 8'(16 * b + 4 * r + k + 1);
            e.m = 24'(4096 * b + 256 * r + 16 * k + 5);
            row[131 - 33 * k -: 33] = e;
        end
        return row;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_row(input logic [131:0] r);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_row   = r;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        chk("push_accept", 132'(acc), 132'(1));
    endtask

    task automatic send_block(input int b);
        for (int r = 0; r < 4; r++) push_row(mkrow(b, r));
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 132'(busy), 132'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        nerr++;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        int fs, p0, l0, s7, n, pc;
        logic [131:0] r;
        logic [6:0]   pat;

        // Reset and first ready
        repeat (3) tick();
        chk("lit_rst_in_ready", 132'(in_ready), 132'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("lit_ready_before_edge", 132'(in_ready), 132'(0));
        tick();
        chk("lit_ready_after_edge", 132'(in_ready), 132'(1));

        // Single block
        out_ready = 1'b1;
        p0 = pop_total;
        l0 = last_total;
        fs = dpv_total;
        for (int i = 0; i < 4; i++) begin
            r = mkrow(1, i);
            r[131:99] = {1'b0, 8'h80, 24'h800000};
            push_row(r);
        end
        in_valid = 1'b0;
        wait_idle();
        chk("lit_t1_dpv", 132'(dpv_total - fs), 132'(4));
        chk("lit_t1_lat", 132'(ovrise_q[0] - first_q[0]), 132'(7));
        chk("lit_t1_e0", 132'(e0_q[0]), 132'(33'h1_7F7F_FFFF));
        chk("lit_t1_pops", 132'(pop_total - p0), 132'(4));
        chk("lit_t1_last", 132'(last_total - l0), 132'(1));

        // Back to back
        fs = first_q.size();
        for (int b = 2; b < 5; b++)
            for (int i = 0; i < 4; i++) push_row(mkrow(b, i));
        in_valid = 1'b0;
        wait_idle();
        chk("lit_b2b_gap0", 132'(first_q[fs+1] - first_q[fs]), 132'(8));
        chk("lit_b2b_gap1", 132'(first_q[fs+2] - first_q[fs+1]), 132'(8));

        // Backpressure
        out_ready = 1'b0;
        fs = dpv_total;
        for (int b = 5; b < 8; b++)
            for (int i = 0; i < 4; i++) push_row(mkrow(b, i));
        in_valid = 1'b0;
        repeat (20) tick();
        chk("lit_bp_ready", 132'(in_ready), 132'(0));
        chk("lit_bp_dpv", 132'(dpv_total - fs), 132'(8));
        fs = first_q.size();
        out_ready = 1'b1;
        pc = cyc;
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (4) tick();
        chk("lit_bp_issue_n", 132'(first_q.size() - fs), 132'(1));
        chk("lit_bp_issue_cyc", 132'(first_q[fs] - pc), 132'(5));
        out_ready = 1'b1;
        wait_idle();

        // Input gaps
        pat = 7'b1011001;
        n = 0;
        fs = first_q.size();
        s7 = 0;
        for (int s = 0; s < 7; s++) begin
            in_valid = pat[s];
            in_row   = mkrow(9, n);
            s7 = cyc;
            tick();
            if (pat[s]) n++;
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("lit_gap_issue_n", 132'(first_q.size() - fs), 132'(1));
        chk("lit_gap_issue_cyc", 132'(first_q[fs] - s7), 132'(1));
        wait_idle();

        // Pop on the ISSUE-entry edge
        out_ready = 1'b0;
        send_block(10);
        repeat (20) tick();
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_row    = mkrow(11, i);
            out_ready = (i == 3);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        send_block(12);
        fs = first_q.size();
        repeat (15) tick();
        chk("lit_sim_wait_ready", 132'(in_ready), 132'(0));
        chk("lit_sim_no_issue", 132'(first_q.size() - fs), 132'(0));
        out_ready = 1'b1;
        pc = cyc;
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (4) tick();
        chk("lit_sim_issue_cyc", 132'(first_q[fs] - pc), 132'(4));
        out_ready = 1'b1;
        wait_idle();

        // Reset during third issue cycle
        send_block(13);
        n = 0;
        @(negedge clk);
        while (!dp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lit_rst_found_issue", 132'(dp_valid), 132'(1));
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("lit_mid_dp_valid", 132'(dp_valid), 132'(0));
        chk("lit_mid_dp_x", dp_x, 132'(0));
        chk("lit_mid_busy", 132'(busy), 132'(0));
        chk("lit_mid_out_valid", 132'(out_valid), 132'(0));
        p0 = pop_total;
        fs = ovrise_q.size();
        repeat (2) tick();
        reset = 1'b1;
        repeat (15) tick();
        chk("lit_post_rst_pops", 132'(pop_total - p0), 132'(0));
        chk("lit_post_rst_ov", 132'(ovrise_q.size() - fs), 132'(0));
        l0 = last_total;
        send_block(14);
        wait_idle();
        chk("lit_fresh_pops", 132'(pop_total - p0), 132'(4));
        chk("lit_fresh_last", 132'(last_total - l0), 132'(1));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
